count_ctrl: RTL and testbench
=============================

Name: count_ctrl

Overview:
- Upstream sequencer for the up/down counter. It drives the counter's en, dir, ld and ld_val pins to run a full profile: load the floor, count up to the ceiling, hold, count back down to the floor.
- It watches the counter's count output as feedback, so every transition happens on an exact count value.
- Software or a top-level FSM starts a profile with a single start pulse and sees busy/done/err status.

Parameters:
- W, 4: counter width; sets the width of ld_val, count_in, cfg_lo and cfg_hi.
- HW, 4: width of the hold-cycle counter and cfg_hold.

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request to begin a profile; sampled only in IDLE.
- stop  in  1  abort request; honoured in any non-IDLE state.
- cfg_lo  in  W  floor value; loaded into the counter and used as the down-count target.
- cfg_hi  in  W  ceiling value; the up-count target.
- cfg_hold  in  HW  number of cycles to hold at the ceiling.
- count_in  in  W  counter's current count (feedback).
- en  out  1  counter enable.
- dir  out  1  counter direction; 1 = up, 0 = down.
- ld  out  1  counter synchronous load.
- ld_val  out  W  counter load value.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when a profile completes normally.
- err  out  1  sticky; set when start arrives with cfg_lo > cfg_hi; cleared by rst or by the next accepted start.

Behaviour:
- Reset: rst sampled high at a rising edge puts the FSM in IDLE and clears the captured cfg, the hold counter and err. All outputs are 0 on the following cycle, including ld_val = 0.
- State and captured cfg are registered. en, dir, ld, ld_val, busy and done are combinational decodes of state and count_in.
- ld and en are never high in the same cycle.
- States: IDLE, LOAD, UP, HOLD, DOWN, DONE.
- IDLE:
  - All outputs 0.
  - start=1 with cfg_lo <= cfg_hi: capture cfg_lo, cfg_hi and cfg_hold, clear err, go to LOAD.
  - start=1 with cfg_lo > cfg_hi: set err and stay in IDLE.
- LOAD:
  - ld=1, ld_val = captured lo. Lasts 1 cycle, then go to UP.
  - Counter shows lo from the first UP cycle.
- UP:
  - dir=1. en=1 while count_in != hi.
  - When count_in == hi: en=0 in that cycle. Next state is HOLD if hold != 0, otherwise DOWN.
  - lo == hi therefore produces zero up-steps.
- HOLD:
  - en=0, dir=1. Stays exactly `hold` cycles using an internal down-counter, then goes to DOWN.
- DOWN:
  - dir=0. en=1 while count_in != lo.
  - When count_in == lo: en=0, go to DONE.
- DONE:
  - done=1 for 1 cycle, en=0, then go to IDLE.
- Latency: start seen at edge N gives LOAD in cycle N+1 and the first up-enable in cycle N+2.
- The controller generates no wrap-around. Because lo <= hi is enforced, neither direction ever crosses the counter's 0 or max boundary.
- stop has priority over all other transitions:
  - Outputs are evaluated normally in the cycle stop is sampled.
  - The next state is IDLE with no done pulse.
  - The counter keeps its value.
- start while busy is ignored.
- Simultaneous start and stop in IDLE: start wins, because stop is not honoured in IDLE.
- rst mid-profile returns the FSM to IDLE on the next edge regardless of state.
- cfg_* inputs may change freely once captured; only the captured copies are used.

Optional Feature:
- Macro: COUNT_CTRL_LOOP_EN.
- Defined:
  - Adds input `loop` (1 bit).
  - In DOWN, when count_in == lo and loop=1, the next state is UP instead of DONE, with no load and no done pulse. The profile repeats until loop=0 at the floor, or stop.
- Undefined:
  - No `loop` port. DOWN always ends in DONE.

Test Plan:
- Reset: rst high 2 cycles mid-UP -> next cycle state IDLE; en, dir, ld, busy, done, err all 0; ld_val=0.
- Basic profile, lo=2 hi=5 hold=3, start pulse:
  - ld=1 with ld_val=2 for 1 cycle.
  - en=1 dir=1 for 3 cycles (count 2->5).
  - en=0 for 1 cycle at 5, then 3 HOLD cycles.
  - en=1 dir=0 for 3 cycles (5->2).
  - done pulse 1 cycle; busy low the cycle after.
- Degenerate, lo=hi=7, hold=0 -> LOAD, UP 1 cycle with en=0, DOWN 1 cycle with en=0, done pulse; count stays 7 throughout.
- Bad config, lo=9 hi=3 start -> err=1, busy stays 0, ld never asserts. Then a start with lo=1 hi=2 -> err clears, profile runs.
- Abort: stop asserted during HOLD of the lo=2 hi=5 profile -> IDLE next cycle, no done, en=0, count stays 5. A start issued during the abort is ignored.
- Loop (COUNT_CTRL_LOOP_EN), lo=0 hi=3 hold=1, loop=1 for two floor hits then 0 -> three up/down passes, a single LOAD, a single done pulse at the end.

Source files
------------

// File: rtl/count_ctrl.sv
// count_ctrl: sequences an up/down counter through load, count-up, hold and count-down.
// Optional COUNT_CTRL_LOOP_EN adds a loop input that repeats the up/down pass at the floor.
module count_ctrl #(
  parameter int W  = 4,
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  cfg_lo,
  input  logic [W-1:0]  cfg_hi,
  input  logic [HW-1:0] cfg_hold,
  input  logic [W-1:0]  count_in,
`ifdef COUNT_CTRL_LOOP_EN
  input  logic          loop,
`endif
  output logic          en,
  output logic          dir,
  output logic          ld,
  output logic [W-1:0]  ld_val,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, LOAD, UP, HOLD, DOWN, DONE} state_t;
  state_t state;
  logic [W-1:0] lo, hi;
  logic [HW-1:0] hold, hcnt;
  logic at_hi, at_lo, again;
  assign at_hi = count_in == hi;
  assign at_lo = count_in == lo;
`ifdef COUNT_CTRL_LOOP_EN
  assign again = loop;
`else
  assign again = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lo    <= '0;
      hi    <= '0;
      hold  <= '0;
      hcnt  <= '0;
      err   <= 1'b0;
    end else if (stop && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (cfg_lo <= cfg_hi) begin
            lo    <= cfg_lo;
            hi    <= cfg_hi;
            hold  <= cfg_hold;
            err   <= 1'b0;
            state <= LOAD;
          end else err <= 1'b1;
        end
        LOAD: state <= UP;
        UP: if (at_hi) begin
          hcnt  <= hold;
          state <= hold != '0 ? HOLD : DOWN;
        end
        HOLD: begin
          hcnt <= hcnt - HW'(1);
          if (hcnt == HW'(1)) state <= DOWN;
        end
        DOWN: if (at_lo) state <= again ? UP : DONE;
        default: state <= IDLE;
      endcase
    end
  end
  assign ld     = state == LOAD;
  assign ld_val = ld ? lo : '0;
  assign en     = (state == UP && !at_hi) || (state == DOWN && !at_lo);
  assign dir    = state == UP || state == HOLD;
  assign busy   = state != IDLE;
  assign done   = state == DONE;
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: random profiles checked cycle by cycle against an expected output trace.
module tb_count_ctrl;
  logic clk = 0, rst = 1, start = 0, stop = 0;
  logic [3:0] cfg_lo = 0, cfg_hi = 0, cfg_hold = 0, cnt, ld_val;
  logic en, dir, ld, busy, done, err;
`ifdef COUNT_CTRL_LOOP_EN
  logic loop = 0;
`endif
  int total = 0, bad = 0;
  logic [9:0] q[$];
  wire [9:0] obs = {en, dir, ld, ld_val, busy, done, err};

  count_ctrl #(.W(4), .HW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_hold(cfg_hold), .count_in(cnt),
`ifdef COUNT_CTRL_LOOP_EN
    .loop(loop),
`endif
    .en(en), .dir(dir), .ld(ld), .ld_val(ld_val), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // the counter being driven; it supplies the feedback
  always @(posedge clk)
    if (rst) cnt <= 0;
    else if (ld) cnt <= ld_val;
    else if (en) cnt <= dir ? cnt + 4'd1 : cnt - 4'd1;

  task automatic chk(string tag, logic [9:0] got, logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ov(bit e, bit d, bit l, int v, bit b, bit dn, bit er);
    return {e, d, l, 4'(v), b, dn, er};
  endfunction

  // expected per-cycle outputs of a whole profile, from load to done
  task automatic build(int lo, int hi, int hold, int passes);
    q.delete();
    q.push_back(ov(0, 0, 1, lo, 1, 0, 0));
    for (int p = 0; p < passes; p++) begin
      repeat (hi - lo) q.push_back(ov(1, 1, 0, 0, 1, 0, 0));
      q.push_back(ov(0, 1, 0, 0, 1, 0, 0));
      repeat (hold) q.push_back(ov(0, 1, 0, 0, 1, 0, 0));
      repeat (hi - lo) q.push_back(ov(1, 0, 0, 0, 1, 0, 0));
      q.push_back(ov(0, 0, 0, 0, 1, 0, 0));
    end
    q.push_back(ov(0, 0, 0, 0, 1, 1, 0));
  endtask

  task automatic run(int lo, int hi, int hold, int passes, int stop_at);
    int e;
    logic [3:0] c;
    build(lo, hi, hold, passes);
    @(negedge clk);
    cfg_lo = 4'(lo); cfg_hi = 4'(hi); cfg_hold = 4'(hold); start = 1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = 0;
      cfg_lo = 4'($urandom); cfg_hi = 4'($urandom); cfg_hold = 4'($urandom);
      chk("trace", obs, q[i]);
`ifdef COUNT_CTRL_LOOP_EN
      loop = i < q.size() - 2;
`endif
      if (i == stop_at) begin
        stop = 1; start = 1;
        break;
      end
    end
    e = stop_at >= 0 ? stop_at : q.size() - 1;
    c = 4'(lo);
    for (int j = 1; j <= e; j++)
      if (q[j][9]) c = q[j][8] ? c + 4'd1 : c - 4'd1;
    @(negedge clk);
    stop = 0; start = 0;
`ifdef COUNT_CTRL_LOOP_EN
    loop = 0;
`endif
    chk("idle", obs, 10'd0);
    chk("count", 10'(cnt), 10'(c));
    @(negedge clk);
    chk("idle2", obs, 10'd0);
    chk("count2", 10'(cnt), 10'(c));
  endtask

  initial begin
    int lo, hi, hold, passes, len, sa;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset", obs, 10'd0);
    run(2, 5, 3, 1, -1);
    run(7, 7, 0, 1, -1);
    @(negedge clk);
    cfg_lo = 9; cfg_hi = 3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) begin
      chk("bad_cfg", obs, ov(0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
    end
    run(1, 2, 0, 1, -1);
    run(2, 5, 3, 1, 6);
`ifdef COUNT_CTRL_LOOP_EN
    run(0, 3, 1, 3, -1);
`endif
    // reset asserted for two edges in the middle of the up phase
    @(negedge clk);
    cfg_lo = 2; cfg_hi = 5; cfg_hold = 3; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("mid_reset", obs, 10'd0);
    repeat (25) begin
      lo = $urandom_range(0, 15);
      hi = $urandom_range(lo, 15);
      hold = $urandom_range(0, 15);
`ifdef COUNT_CTRL_LOOP_EN
      passes = $urandom_range(1, 3);
`else
      passes = 1;
`endif
      len = 2 + passes * (2 * (hi - lo) + 2 + hold);
      sa = $urandom_range(0, 2) == 0 ? $urandom_range(0, len - 1) : -1;
      run(lo, hi, hold, passes, sa);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
